axil_initiator_port: RTL and testbench

- Synthesizable single-outstanding AXI4-Lite initiator (master): the requesting end of the AXI4-Lite memory interface used throughout the codebase.
- Takes simple read/write commands on a valid/ready command port, runs them as full AXI4-Lite transactions, and returns data, error and latency on a response port.
- Serves as the bus driver for DMA-like helpers and as a synthesizable traffic source against AXI memory responders.

---
 rtl/axil_pkg.sv | 29 ++
 rtl/axil_initiator_port_if.sv | 83 ++++++++
 rtl/axil_chan_driver.sv | 37 +++
 rtl/axil_initiator_port.sv | 172 +++++++++++++++++
 tb/tb_axil_initiator_port.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite initiator port.
//   state_e     : controller state encodings
//   RESP_*      : AXI response codes
//   PROT_INSN   : prot bit marking an instruction access
//   resp_is_err : AXI response -> single error flag
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int PROT_INSN = 2;

  // SLVERR and DECERR both carry bit 1, so one bit is the whole error story.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axil_initiator_port_if.sv
// Bundle of the command port, response port and the five AXI4-Lite channels.
//   master : view of the initiator (takes commands, drives AXI requests)
//   slave  : view of everything around it (command source, response sink,
//            AXI memory responder)
interface axil_initiator_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 16
) ();

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_wstrb;
  logic [2:0]                cmd_prot;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;
  logic [LAT_WIDTH-1:0]      resp_latency;

  logic                      axi_awvalid;
  logic                      axi_awready;
  logic [ADDR_WIDTH-1:0]     axi_awaddr;
  logic [2:0]                axi_awprot;

  logic                      axi_wvalid;
  logic                      axi_wready;
  logic [DATA_WIDTH-1:0]     axi_wdata;
  logic [DATA_WIDTH/8-1:0]   axi_wstrb;

  logic                      axi_bvalid;
  logic                      axi_bready;
  logic [1:0]                axi_bresp;

  logic                      axi_arvalid;
  logic                      axi_arready;
  logic [ADDR_WIDTH-1:0]     axi_araddr;
  logic [2:0]                axi_arprot;

  logic                      axi_rvalid;
  logic                      axi_rready;
  logic [DATA_WIDTH-1:0]     axi_rdata;
  logic [1:0]                axi_rresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
    output cmd_ready,
    output resp_valid, resp_rdata, resp_err, resp_latency,
    input  resp_ready,
    output axi_awvalid, axi_awaddr, axi_awprot,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb,
    input  axi_wready,
    input  axi_bvalid, axi_bresp,
    output axi_bready,
    output axi_arvalid, axi_araddr, axi_arprot,
    input  axi_arready,
    input  axi_rvalid, axi_rdata, axi_rresp,
    output axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
    input  cmd_ready,
    input  resp_valid, resp_rdata, resp_err, resp_latency,
    output resp_ready,
    input  axi_awvalid, axi_awaddr, axi_awprot,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb,
    output axi_wready,
    output axi_bvalid, axi_bresp,
    input  axi_bready,
    input  axi_arvalid, axi_araddr, axi_arprot,
    output axi_arready,
    output axi_rvalid, axi_rdata, axi_rresp,
    input  axi_rready
  );

endinterface

// File: rtl/axil_chan_driver.sv
// Valid-hold register for one AXI request channel (AW, W or AR).
//   i_load    : capture i_payload and raise o_valid on the next cycle
//   i_payload : channel payload (address+prot, or data+strobe)
//   i_ready   : channel ready from the responder
//   o_valid   : held high until the cycle after the handshake
//   o_payload : registered payload, stable for as long as o_valid is high
module axil_chan_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_payload,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_payload
);

  logic             r_valid;
  logic [WIDTH-1:0] r_payload;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
    end else if (r_valid && i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/axil_initiator_port.sv
// Single-outstanding AXI4-Lite initiator.
// Accepts read/write commands on a valid/ready port, runs each one as a full
// AXI4-Lite transaction and returns data, error flag and latency.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : command, response and AXI4-Lite channels (master view)
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR_REQ  | AW and W offered, each dropping after its own handshake
// ST_WR_RESP | bready high, waiting for the write response
// ST_RD_REQ  | AR offered, waiting for arready
// ST_RD_DATA | rready high, waiting for read data
// ST_RESP    | response presented, held until resp_ready
module axil_initiator_port
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  axil_initiator_port_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int AX_WIDTH   = ADDR_WIDTH + 3;
  localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [LAT_WIDTH-1:0]  r_lat;

  logic                  w_cmd_fire;
  logic                  w_busy;
  logic                  w_bready;
  logic                  w_rready;
  logic                  w_resp_valid;
  logic                  w_aw_done;
  logic                  w_w_done;

  logic                  w_awvalid;
  logic                  w_wvalid;
  logic                  w_arvalid;
  logic [AX_WIDTH-1:0]   w_aw_payload;
  logic [W_WIDTH-1:0]    w_w_payload;
  logic [AX_WIDTH-1:0]   w_ar_payload;

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign w_cmd_fire    = bus.cmd_valid && bus.cmd_ready;

  axil_chan_driver #(.WIDTH(AX_WIDTH)) u_aw (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_cmd_fire && bus.cmd_write),
    .i_payload ({bus.cmd_prot, bus.cmd_addr}),
    .i_ready   (bus.axi_awready),
    .o_valid   (w_awvalid),
    .o_payload (w_aw_payload)
  );

  axil_chan_driver #(.WIDTH(W_WIDTH)) u_w (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_cmd_fire && bus.cmd_write),
    .i_payload ({bus.cmd_wstrb, bus.cmd_wdata}),
    .i_ready   (bus.axi_wready),
    .o_valid   (w_wvalid),
    .o_payload (w_w_payload)
  );

  axil_chan_driver #(.WIDTH(AX_WIDTH)) u_ar (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_cmd_fire && !bus.cmd_write),
    .i_payload ({bus.cmd_prot, bus.cmd_addr}),
    .i_ready   (bus.axi_arready),
    .o_valid   (w_arvalid),
    .o_payload (w_ar_payload)
  );

  assign bus.axi_awvalid = w_awvalid;
  assign bus.axi_awaddr  = w_aw_payload[ADDR_WIDTH-1:0];
  assign bus.axi_awprot  = w_aw_payload[AX_WIDTH-1:ADDR_WIDTH];
  assign bus.axi_wvalid  = w_wvalid;
  assign bus.axi_wdata   = w_w_payload[DATA_WIDTH-1:0];
  assign bus.axi_wstrb   = w_w_payload[W_WIDTH-1:DATA_WIDTH];
  assign bus.axi_arvalid = w_arvalid;
  assign bus.axi_araddr  = w_ar_payload[ADDR_WIDTH-1:0];
  assign bus.axi_arprot  = w_ar_payload[AX_WIDTH-1:ADDR_WIDTH];

  // Both valids are loaded on acceptance, so inside WR_REQ a low valid means
  // that channel has already handshaken; a high valid with ready completes now.
  assign w_aw_done = !w_awvalid || bus.axi_awready;
  assign w_w_done  = !w_wvalid  || bus.axi_wready;

  assign w_busy = (r_state == ST_WR_REQ)  || (r_state == ST_WR_RESP) ||
                  (r_state == ST_RD_REQ)  || (r_state == ST_RD_DATA);

  always_comb begin
    w_state_nxt  = r_state;
    w_bready     = 1'b0;
    w_rready     = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) w_state_nxt = bus.cmd_write ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        // bready is already high here, but B is only sampled in WR_RESP.
        w_bready = 1'b1;
        if (w_aw_done && w_w_done) w_state_nxt = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        w_bready = 1'b1;
        if (bus.axi_bvalid) w_state_nxt = ST_RESP;
      end
      ST_RD_REQ: begin
        if (bus.axi_arready) w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        w_rready = 1'b1;
        if (bus.axi_rvalid) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;

      // The acceptance cycle counts as cycle 1; the final handshake cycle is
      // included, so a zero-wait write or read reports 3.
      if (w_cmd_fire) begin
        r_lat <= LAT_WIDTH'(1);
      end else if (w_busy && (r_lat != '1)) begin
        r_lat <= r_lat + LAT_WIDTH'(1);
      end

      if ((r_state == ST_WR_RESP) && bus.axi_bvalid) begin
        r_rdata <= '0;
        r_err   <= resp_is_err(bus.axi_bresp);
      end
      if ((r_state == ST_RD_DATA) && bus.axi_rvalid) begin
        r_rdata <= bus.axi_rdata;
        r_err   <= resp_is_err(bus.axi_rresp);
      end
    end
  end

  assign bus.axi_bready   = w_bready;
  assign bus.axi_rready   = w_rready;
  assign bus.resp_valid   = w_resp_valid;
  assign bus.resp_rdata   = r_rdata;
  assign bus.resp_err     = r_err;
  assign bus.resp_latency = r_lat;

endmodule

// File: tb/tb_axil_initiator_port.sv
module tb_axil_initiator_port;
  import axil_pkg::*;

  logic clk;
  logic reset;

  axil_initiator_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LAT_WIDTH(16)) bus ();

  axil_initiator_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LAT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Responder configuration (set by the scenario tasks)
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;

  // Responder memory and the bench's own expected memory
  logic [31:0] mem     [0:255] = '{default: 32'h0};
  logic [31:0] exp_mem [0:255] = '{default: 32'h0};

  // Responder state and observation counters
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic [31:0] got_awaddr, got_wdata, r_data_q;
  logic [3:0]  got_wstrb;
  int          cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
  int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  logic [31:0] last_awaddr = 0, last_araddr = 0;
  logic [2:0]  last_awprot = 0, last_arprot = 0;
  int          proto_err = 0;
  bit          prev_aw_pend = 0, prev_w_pend = 0, prev_ar_pend = 0;
  logic [34:0] prev_aw_pay, prev_ar_pay;
  logic [35:0] prev_w_pay;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      prev_aw_pend = 0; prev_w_pend = 0; prev_ar_pend = 0;
    end else begin
      // A pending valid must stay up with an unchanged payload
      if (prev_aw_pend && (!bus.axi_awvalid || {bus.axi_awprot, bus.axi_awaddr} != prev_aw_pay)) proto_err++;
      if (prev_w_pend  && (!bus.axi_wvalid  || {bus.axi_wstrb, bus.axi_wdata}   != prev_w_pay))  proto_err++;
      if (prev_ar_pend && (!bus.axi_arvalid || {bus.axi_arprot, bus.axi_araddr} != prev_ar_pay)) proto_err++;

      if (bus.axi_awvalid && bus.axi_awready) begin
        aw_got = 1; aw_wait = 0; got_awaddr = bus.axi_awaddr; aw_hs_n++; aw_hs_cyc = cyc;
        last_awaddr = bus.axi_awaddr; last_awprot = bus.axi_awprot;
      end
      if (bus.axi_wvalid && bus.axi_wready) begin
        w_got = 1; w_wait = 0; got_wdata = bus.axi_wdata; got_wstrb = bus.axi_wstrb; w_hs_n++; w_hs_cyc = cyc;
      end
      if (bus.axi_bvalid && bus.axi_bready) begin
        b_pend = 0; b_wait = 0; b_hs_n++;
      end
      if (aw_got && w_got && !b_pend) begin
        if (!cfg_bresp[1]) begin
          for (int b = 0; b < 4; b++)
            if (got_wstrb[b]) mem[got_awaddr[9:2]][8*b +: 8] = got_wdata[8*b +: 8];
        end
        b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0;
      end
      if (bus.axi_rvalid && bus.axi_rready) begin
        r_pend = 0; r_wait = 0; r_hs_n++;
      end
      if (bus.axi_arvalid && bus.axi_arready) begin
        r_pend = 1; r_wait = 0; r_data_q = mem[bus.axi_araddr[9:2]]; ar_hs_n++; ar_wait = 0;
        last_araddr = bus.axi_araddr; last_arprot = bus.axi_arprot;
      end

      prev_aw_pend = bus.axi_awvalid && !bus.axi_awready;
      prev_w_pend  = bus.axi_wvalid  && !bus.axi_wready;
      prev_ar_pend = bus.axi_arvalid && !bus.axi_arready;
      prev_aw_pay  = {bus.axi_awprot, bus.axi_awaddr};
      prev_w_pay   = {bus.axi_wstrb, bus.axi_wdata};
      prev_ar_pay  = {bus.axi_arprot, bus.axi_araddr};
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_arready = 0;
      bus.axi_bvalid = 0; bus.axi_bresp = 0; bus.axi_rvalid = 0; bus.axi_rdata = 0; bus.axi_rresp = 0;
    end else begin
      bus.axi_awready = bus.axi_awvalid && !aw_got && (aw_wait >= aw_dly);
      if (bus.axi_awvalid && !aw_got) aw_wait++;
      bus.axi_wready = bus.axi_wvalid && !w_got && (w_wait >= w_dly);
      if (bus.axi_wvalid && !w_got) w_wait++;
      bus.axi_arready = bus.axi_arvalid && !r_pend && (ar_wait >= ar_dly);
      if (bus.axi_arvalid && !r_pend) ar_wait++;
      bus.axi_bvalid = b_pend && (b_wait >= b_dly);
      bus.axi_bresp  = cfg_bresp;
      if (b_pend) b_wait++;
      bus.axi_rvalid = r_pend && (r_wait >= r_dly);
      bus.axi_rdata  = bus.axi_rvalid ? r_data_q : 32'h0;
      bus.axi_rresp  = cfg_rresp;
      if (r_pend) r_wait++;
    end
  end

  // Reference model: latency from the responder's wait counts, saturating
  function automatic logic [15:0] exp_lat(input int req_cycles, input int resp_dly);
    int l;
    l = 2 + req_cycles + resp_dly;
    return (l > 65535) ? 16'hFFFF : 16'(l);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] word;
    word = exp_mem[addr[9:2]];
    for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
    exp_mem[addr[9:2]] = word;
  endtask

  // One command through the port; hold = cycles to keep resp_ready low
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot, input int limit, input int hold,
                         output logic [31:0] rdata, output logic err, output logic [15:0] lat,
                         output bit to, output bit stable);
    int n;
    to = 0; stable = 1; rdata = 0; err = 0; lat = 0;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = data; bus.cmd_wstrb = strb; bus.cmd_prot = prot;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.cmd_valid = 0; bus.cmd_write = $urandom_range(0, 1); bus.cmd_addr = $urandom;
    bus.cmd_wdata = $urandom; bus.cmd_wstrb = 4'($urandom); bus.cmd_prot = 3'($urandom);
    n = 0;
    while (!bus.resp_valid && n < limit) begin @(negedge clk); n++; end
    if (!bus.resp_valid) begin to = 1; return; end
    rdata = bus.resp_rdata; err = bus.resp_err; lat = bus.resp_latency;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_rdata !== rdata || bus.resp_err !== err ||
          bus.resp_latency !== lat || bus.cmd_ready !== 1'b0) stable = 0;
    end
    bus.resp_ready = 1;
    @(negedge clk);
    bus.resp_ready = 0;
  endtask

  task automatic check_outputs_reset(input string name);
    checks++;
    if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready,
         bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.resp_latency, bus.axi_awaddr,
         bus.axi_awprot, bus.axi_wdata, bus.axi_wstrb, bus.axi_araddr, bus.axi_arprot} !== '0) begin
      failures++;
      $display("FAIL %s_outputs: got aw%b w%b b%b ar%b r%b rv%b err%b rdata=%h lat=%h awaddr=%h araddr=%h, expected all zero",
               name, bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready,
               bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.resp_latency, bus.axi_awaddr, bus.axi_araddr);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_cmd_ready: got %b expected 1", name, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    check_outputs_reset("reset");
    reset = 0;
  endtask

  task automatic test_write();
    logic [31:0] rd; logic er; logic [15:0] lt; bit to, st;
    aw_dly = 0; w_dly = 0; b_dly = 0; cfg_bresp = RESP_OKAY;
    run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 200, 0, rd, er, lt, to, st);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (to) begin failures++; $display("FAIL write_timeout: no response, expected one"); end
    checks++; if (aw_hs_cyc != w_hs_cyc) begin failures++; $display("FAIL write_aw_w_same_cycle: aw at %0d w at %0d, expected equal", aw_hs_cyc, w_hs_cyc); end
    checks++; if (last_awaddr !== 32'h10) begin failures++; $display("FAIL write_awaddr: got %h expected 00000010", last_awaddr); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL write_err: got %b expected 0", er); end
    checks++; if (lt !== 16'd3) begin failures++; $display("FAIL write_latency: got %0d expected 3", lt); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL write_rdata: got %h expected 0", rd); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL write_mem: got %h expected deadbeef", mem[4]); end
  endtask

  task automatic test_read_after_write();
    logic [31:0] rd; logic er; logic [15:0] lt; bit to, st;
    logic [2:0] prot;
    prot = 3'b000; prot[PROT_INSN] = 1'b1;
    ar_dly = 0; r_dly = 0; cfg_rresp = RESP_OKAY;
    run_txn(0, 32'h10, 32'h0, 4'h0, prot, 200, 0, rd, er, lt, to, st);
    checks++; if (to) begin failures++; $display("FAIL raw_timeout: no response, expected one"); end
    checks++; if (last_arprot !== 3'b100) begin failures++; $display("FAIL raw_arprot: got %b expected 100", last_arprot); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_rdata: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL raw_err: got %b expected 0", er); end
    checks++; if (lt !== 16'd3) begin failures++; $display("FAIL raw_latency: got %0d expected 3", lt); end
  endtask

  task automatic test_skew();
    logic [31:0] rd, d, a; logic er; logic [15:0] lt; bit to, st;
    int aw0, w0, b0, pe0;
    for (int k = 0; k < 2; k++) begin
      aw_dly = (k == 0) ? 0 : 4; w_dly = (k == 0) ? 4 : 0; b_dly = 0; cfg_bresp = RESP_OKAY;
      aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; pe0 = proto_err;
      a = {22'd0, 8'($urandom), 2'b00}; d = $urandom;
      run_txn(1, a, d, 4'hF, 3'b001, 200, 0, rd, er, lt, to, st);
      model_write(a, d, 4'hF);
      checks++; if (to) begin failures++; $display("FAIL skew%0d_timeout: no response, expected one", k); end
      checks++; if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1 || b_hs_n - b0 != 1) begin
        failures++; $display("FAIL skew%0d_handshakes: aw=%0d w=%0d b=%0d expected 1 each", k, aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0); end
      checks++; if ((k == 0 ? w_hs_cyc - aw_hs_cyc : aw_hs_cyc - w_hs_cyc) != 4) begin
        failures++; $display("FAIL skew%0d_order: aw at %0d w at %0d expected 4 apart", k, aw_hs_cyc, w_hs_cyc); end
      checks++; if (proto_err != pe0) begin failures++; $display("FAIL skew%0d_valid_hold: %0d violations expected 0", k, proto_err - pe0); end
      checks++; if (lt !== exp_lat(1 + max2(aw_dly, w_dly), b_dly)) begin
        failures++; $display("FAIL skew%0d_latency: got %0d expected %0d", k, lt, exp_lat(1 + max2(aw_dly, w_dly), b_dly)); end
      checks++; if (mem[a[9:2]] !== exp_mem[a[9:2]]) begin failures++; $display("FAIL skew%0d_mem: got %h expected %h", k, mem[a[9:2]], exp_mem[a[9:2]]); end
    end
    aw_dly = 0; w_dly = 0;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; logic [15:0] lt; bit to, st;
    cfg_bresp = RESP_SLVERR;
    run_txn(1, 32'h20, 32'h12345678, 4'hF, 3'b000, 200, 0, rd, er, lt, to, st);
    cfg_bresp = RESP_OKAY;
    checks++; if (to || er !== 1'b1) begin failures++; $display("FAIL slverr_err: got %b (timeout %0d) expected 1", er, to); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL slverr_rdata: got %h expected 0", rd); end
    cfg_rresp = RESP_DECERR;
    run_txn(0, 32'h10, 32'h0, 4'h0, 3'b000, 200, 0, rd, er, lt, to, st);
    cfg_rresp = RESP_OKAY;
    checks++; if (to || er !== 1'b1) begin failures++; $display("FAIL decerr_err: got %b (timeout %0d) expected 1", er, to); end
    checks++; if (rd !== exp_mem[4]) begin failures++; $display("FAIL decerr_rdata: got %h expected %h", rd, exp_mem[4]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; logic [15:0] lt; bit to, st;
    run_txn(0, 32'h10, 32'h0, 4'h0, 3'b000, 200, 5, rd, er, lt, to, st);
    checks++; if (to || !st) begin failures++; $display("FAIL bp_stable: stable=%0d timeout=%0d expected stable=1 timeout=0", st, to); end
    checks++; if (rd !== exp_mem[4]) begin failures++; $display("FAIL bp_rdata: got %h expected %h", rd, exp_mem[4]); end
    b_dly = 70000;
    run_txn(1, 32'h40, 32'hA5A5A5A5, 4'hF, 3'b000, 80000, 0, rd, er, lt, to, st);
    model_write(32'h40, 32'hA5A5A5A5, 4'hF);
    b_dly = 0;
    checks++; if (to || lt !== 16'hFFFF) begin failures++; $display("FAIL sat_latency: got %h (timeout %0d) expected ffff", lt, to); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; logic [15:0] lt; bit to, st;
    int n;
    r_dly = 20;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 32'h10; bus.cmd_prot = 3'b010;
    @(negedge clk);
    bus.cmd_valid = 0;
    n = 0;
    while (!bus.axi_rready && n < 50) begin @(negedge clk); n++; end
    checks++; if (!bus.axi_rready) begin failures++; $display("FAIL midrst_reach_rdata: rready=%b expected 1", bus.axi_rready); end
    reset = 1;
    @(negedge clk);
    check_outputs_reset("midrst");
    reset = 0;
    r_dly = 0;
    run_txn(0, 32'h40, 32'h0, 4'h0, 3'b000, 200, 0, rd, er, lt, to, st);
    checks++; if (to || rd !== exp_mem[16] || er !== 1'b0 || lt !== 16'd3) begin
      failures++; $display("FAIL midrst_read: rdata=%h err=%b lat=%0d timeout=%0d expected rdata=%h err=0 lat=3", rd, er, lt, to, exp_mem[16]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d; logic er; logic [15:0] lt; bit to, st;
    logic [3:0] s; logic [2:0] p; bit wr;
    logic [31:0] e_rd; logic e_er; logic [15:0] e_lt;
    int pe0;
    pe0 = proto_err;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      a = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      d = $urandom; s = 4'($urandom); p = 3'($urandom);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom);
      if (wr) begin
        e_rd = 0; e_er = cfg_bresp[1]; e_lt = exp_lat(1 + max2(aw_dly, w_dly), b_dly);
        if (!cfg_bresp[1]) model_write(a, d, s);
      end else begin
        e_rd = exp_mem[a[9:2]]; e_er = cfg_rresp[1]; e_lt = exp_lat(1 + ar_dly, r_dly);
      end
      run_txn(wr, a, d, s, p, 200, 0, rd, er, lt, to, st);
      checks++;
      if (to || rd !== e_rd || er !== e_er || lt !== e_lt ||
          (wr ? {last_awprot, last_awaddr} : {last_arprot, last_araddr}) !== {p, a}) begin
        failures++;
        $display("FAIL rand%0d_%s: rdata=%h err=%b lat=%0d to=%0d, expected rdata=%h err=%b lat=%0d addr=%h prot=%b",
                 t, wr ? "wr" : "rd", rd, er, lt, to, e_rd, e_er, e_lt, a, p);
      end
    end
    checks++; if (proto_err != pe0) begin failures++; $display("FAIL rand_valid_hold: %0d violations expected 0", proto_err - pe0); end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY;
  endtask

  initial begin
    reset = 1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.cmd_wstrb = 0; bus.cmd_prot = 0; bus.resp_ready = 0;
    test_reset();
    test_write();
    test_read_after_write();
    test_skew();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
